// File: rtl/gf2m_alu_pkg.sv
// Shared opcodes, FSM states and sizing helper for the GF(2^M) digit-serial ALU.
package gf2m_alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_SQR = 4'b0100;
  localparam logic [3:0] OP_DEG = 4'b0111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } alu_state_t;

  function automatic int num_digits(input int m, input int d);
    return (m + d - 1) / d;
  endfunction

endpackage

// File: rtl/gf2m_digit_mac.sv
// One digit-serial multiplier step: acc*x^D mod f ^ A*digit mod f, evaluated
// bit by bit (Horner) so every intermediate stays reduced to M bits.
module gf2m_digit_mac #(
  parameter int M = 144,
  parameter int D = 8
) (
  input  logic [M-1:0] acc,
  input  logic [M-1:0] a,
  input  logic [D-1:0] digit,
  input  logic [M:0]   f,
  output logic [M-1:0] acc_next
);

  logic [M-1:0] t_acc;
  logic [M:0]   shifted;

  always_comb begin
    t_acc   = acc;
    shifted = '0;
    for (int j = D - 1; j >= 0; j--) begin
      shifted = {t_acc, 1'b0};
      if (shifted[M]) shifted = shifted ^ f;
      t_acc = shifted[M-1:0] ^ (digit[j] ? a : '0);
    end
    acc_next = t_acc;
  end

endmodule

// File: rtl/gf2m_digit_alu.sv
// Parametrised GF(2^M) polynomial-basis ALU with digit-serial MUL.
// Optional feature macro: GF2M_ALU_SQR_EN enables opcode 0100 (squaring).
module gf2m_digit_alu
  import gf2m_alu_pkg::*;
#(
  parameter int M = 144,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         alu_start,
  input  logic [3:0]   alu_typ_sel,
  input  logic [M-1:0] alu_o_dat,
  input  logic [M-1:0] alu_t_dat,
  input  logic         alu_mod_sel,
  input  logic [M:0]   alu_mod_dat,
  output logic         alu_busy,
  output logic [M-1:0] alu_r_dat1,
  output logic         compute_done,
  output logic         alu_err
);

  localparam int N  = num_digits(M, D);
  localparam int NB = N * D;
  localparam int CW = $clog2(N + 1);

  alu_state_t state, state_next;

  logic [M-1:0]  a_reg;
  logic [M-1:0]  acc;
  logic [NB-1:0] b_reg;
  logic [M:0]    mod_reg;
  logic [CW-1:0] cnt;
  logic [M-1:0]  mac_out;
  logic [M-1:0]  b_src;
  logic [M-1:0]  deg_res;
  logic          op_mul;
  logic          op_legal;
  logic          last_iter;

  assign alu_busy     = (state == RUN);
  assign compute_done = (state == DONE);
  assign last_iter    = (cnt == CW'(N - 1));

  always_comb begin
    op_mul   = (alu_typ_sel == OP_MUL);
    b_src    = alu_t_dat;
`ifdef GF2M_ALU_SQR_EN
    if (alu_typ_sel == OP_SQR) begin
      op_mul = 1'b1;
      b_src  = alu_o_dat;
    end
`endif
    op_legal = op_mul || (alu_typ_sel == OP_ADD) || (alu_typ_sel == OP_DEG);
  end

  // Highest set bit wins; a zero operand has no degree and reports all-ones.
  always_comb begin
    deg_res = '1;
    for (int i = 0; i < M; i++) begin
      if (alu_o_dat[i]) deg_res = M'(i);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (alu_start) state_next = op_mul ? RUN : DONE;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Single-cycle ops finish at the acceptance edge; MUL/SQR write the result
  // on the final iteration so it is already valid while compute_done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      acc        <= '0;
      cnt        <= '0;
      mod_reg    <= '0;
      alu_r_dat1 <= '0;
      alu_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (alu_mod_sel) mod_reg <= alu_mod_dat;
          if (alu_start) begin
            a_reg <= alu_o_dat;
            b_reg <= NB'(b_src);
            acc   <= '0;
            cnt   <= '0;
            if (!op_mul) begin
              alu_err <= !op_legal;
              if (alu_typ_sel == OP_ADD)      alu_r_dat1 <= alu_o_dat ^ alu_t_dat;
              else if (alu_typ_sel == OP_DEG) alu_r_dat1 <= deg_res;
            end
          end
        end
        RUN: begin
          acc   <= mac_out;
          b_reg <= b_reg << D;
          cnt   <= cnt + 1'b1;
          if (last_iter) begin
            alu_r_dat1 <= mac_out;
            alu_err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  gf2m_digit_mac #(
    .M(M),
    .D(D)
  ) u_mac (
    .acc     (acc),
    .a       (a_reg),
    .digit   (b_reg[NB-1 -: D]),
    .f       (mod_reg),
    .acc_next(mac_out)
  );

endmodule

// File: tb/tb_gf2m_digit_alu.sv
// Directed self-checking bench: three M=8 ALUs (D=4,1,8) on shared stimulus
// plus one M=144, D=8 ALU for the full-size, overlap and abort cases.
module tb_gf2m_digit_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic [3:0] op;
  logic [7:0] a, b;
  logic       mod_sel;
  logic [8:0] mod_dat;

  logic       busy4, busy1, busy8;
  logic [7:0] r4, r1, r8;
  logic       done4, done1, done8;
  logic       err4, err1, err8;

  logic         bstart;
  logic [3:0]   bop;
  logic [143:0] ba, bb;
  logic         bmod_sel;
  logic [144:0] bmod;
  logic         bbusy, bdone, berr;
  logic [143:0] br;

  int errors = 0;
  int checks = 0;
  int cyc4, cyc1, cyc8, busy_cnt;
  int bcyc, bdone_cnt;
  logic [143:0] bres;

  gf2m_digit_alu #(.M(8), .D(4)) u_d4 (
    .clk(clk), .rst(rst), .alu_start(start), .alu_typ_sel(op), .alu_o_dat(a), .alu_t_dat(b),
    .alu_mod_sel(mod_sel), .alu_mod_dat(mod_dat), .alu_busy(busy4), .alu_r_dat1(r4),
    .compute_done(done4), .alu_err(err4));

  gf2m_digit_alu #(.M(8), .D(1)) u_d1 (
    .clk(clk), .rst(rst), .alu_start(start), .alu_typ_sel(op), .alu_o_dat(a), .alu_t_dat(b),
    .alu_mod_sel(mod_sel), .alu_mod_dat(mod_dat), .alu_busy(busy1), .alu_r_dat1(r1),
    .compute_done(done1), .alu_err(err1));

  gf2m_digit_alu #(.M(8), .D(8)) u_d8 (
    .clk(clk), .rst(rst), .alu_start(start), .alu_typ_sel(op), .alu_o_dat(a), .alu_t_dat(b),
    .alu_mod_sel(mod_sel), .alu_mod_dat(mod_dat), .alu_busy(busy8), .alu_r_dat1(r8),
    .compute_done(done8), .alu_err(err8));

  gf2m_digit_alu #(.M(144), .D(8)) u_big (
    .clk(clk), .rst(rst), .alu_start(bstart), .alu_typ_sel(bop), .alu_o_dat(ba), .alu_t_dat(bb),
    .alu_mod_sel(bmod_sel), .alu_mod_dat(bmod), .alu_busy(bbusy), .alu_r_dat1(br),
    .compute_done(bdone), .alu_err(berr));

  task automatic checkOutput(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op to the M=8 ALUs and record the cycle of each compute_done.
  task automatic applyStimulus(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb);
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    @(negedge clk);
    start = 1'b0; a = 8'h00; b = 8'h00;
    cyc4 = 0; cyc1 = 0; cyc8 = 0; busy_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      if (done4 && cyc4 == 0) cyc4 = c;
      if (done1 && cyc1 == 0) cyc1 = c;
      if (done8 && cyc8 == 0) cyc8 = c;
      if (busy4) busy_cnt++;
      if (c < 12) @(negedge clk);
    end
  endtask

  // Issue one op to the M=144 ALU; optionally pulse a second start in cycle 5.
  task automatic bigOp(input logic [3:0] o, input logic [143:0] va, input logic [143:0] vb,
                       input logic load_mod, input logic poke);
    @(negedge clk);
    bstart = 1'b1; bop = o; ba = va; bb = vb; bmod_sel = load_mod;
    @(negedge clk);
    bstart = 1'b0; bmod_sel = 1'b0; ba = '0; bb = '0;
    bcyc = 0; bdone_cnt = 0; bres = '0;
    for (int c = 1; c <= 30; c++) begin
      if (bdone) begin
        bdone_cnt++;
        if (bcyc == 0) begin
          bcyc = c;
          bres = br;
        end
      end
      bstart = poke && (c == 5);
      if (bstart) bop = 4'b0001;
      if (c < 30) @(negedge clk);
    end
    bstart = 1'b0;
  endtask

  initial begin
    logic [143:0] x143;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; mod_sel = 1'b0; mod_dat = '0;
    bstart = 1'b0; bop = '0; ba = '0; bb = '0; bmod_sel = 1'b0; bmod = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_r",    160'(r4), 160'(0));
    checkOutput("reset_done", 160'(done4), 160'(0));
    checkOutput("reset_busy", 160'(busy4), 160'(0));
    checkOutput("reset_err",  160'(err4), 160'(0));
    rst = 1'b0;

    @(negedge clk); mod_sel = 1'b1; mod_dat = 9'h11B;
    @(negedge clk); mod_sel = 1'b0; mod_dat = '0;

    applyStimulus(4'b0001, 8'h57, 8'h83);
    checkOutput("add_cycle", 160'(cyc4), 160'(1));
    checkOutput("add_r",     160'(r4), 160'(8'hD4));
    checkOutput("add_err",   160'(err4), 160'(0));

    applyStimulus(4'b0011, 8'h57, 8'h83);
    checkOutput("mul_d4_cycle", 160'(cyc4), 160'(3));
    checkOutput("mul_d4_busy",  160'(busy_cnt), 160'(2));
    checkOutput("mul_d4_r",     160'(r4), 160'(8'hC1));
    checkOutput("mul_d4_err",   160'(err4), 160'(0));
    checkOutput("mul_d1_cycle", 160'(cyc1), 160'(9));
    checkOutput("mul_d1_r",     160'(r1), 160'(8'hC1));
    checkOutput("mul_d8_cycle", 160'(cyc8), 160'(2));
    checkOutput("mul_d8_r",     160'(r8), 160'(8'hC1));

    applyStimulus(4'b0100, 8'h57, 8'h00);
`ifdef GF2M_ALU_SQR_EN
    checkOutput("sqr_cycle", 160'(cyc4), 160'(3));
    checkOutput("sqr_r",     160'(r4), 160'(8'hA5));
    checkOutput("sqr_err",   160'(err4), 160'(0));
    checkOutput("sqr_d1_r",  160'(r1), 160'(8'hA5));
`else
    checkOutput("sqr_cycle", 160'(cyc4), 160'(1));
    checkOutput("sqr_r",     160'(r4), 160'(8'hC1));
    checkOutput("sqr_err",   160'(err4), 160'(1));
`endif

    applyStimulus(4'b0111, 8'h57, 8'h00);
    checkOutput("deg_r",   160'(r4), 160'(6));
    checkOutput("deg_err", 160'(err4), 160'(0));
    applyStimulus(4'b0111, 8'h00, 8'h00);
    checkOutput("deg0_r",  160'(r4), 160'(8'hFF));

    applyStimulus(4'b1111, 8'h12, 8'h34);
    checkOutput("ill_cycle", 160'(cyc4), 160'(1));
    checkOutput("ill_err",   160'(err4), 160'(1));
    checkOutput("ill_r",     160'(r4), 160'(8'hFF));

    x143 = '0; x143[143] = 1'b1;
    bmod = '0; bmod[144] = 1'b1; bmod[1] = 1'b1; bmod[0] = 1'b1;
    bigOp(4'b0011, x143, 144'(2), 1'b1, 1'b1);
    checkOutput("big_cycle", 160'(bcyc), 160'(19));
    checkOutput("big_ndone", 160'(bdone_cnt), 160'(1));
    checkOutput("big_r",     160'(bres), 160'(3));
    checkOutput("big_err",   160'(berr), 160'(0));

    // Abort a MUL in cycle 5 with reset.
    @(negedge clk);
    bstart = 1'b1; bop = 4'b0011; ba = x143; bb = 144'(2);
    @(negedge clk);
    bstart = 1'b0;
    bdone_cnt = 0;
    for (int c = 1; c < 5; c++) begin
      if (bdone) bdone_cnt++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_done", 160'(bdone), 160'(0));
    checkOutput("abort_busy", 160'(bbusy), 160'(0));
    checkOutput("abort_r",    160'(br), 160'(0));
    checkOutput("abort_err",  160'(berr), 160'(0));
    for (int c = 0; c < 25; c++) begin
      if (bdone) bdone_cnt++;
      @(negedge clk);
    end
    checkOutput("abort_ndone", 160'(bdone_cnt), 160'(0));

    bigOp(4'b0001, 144'(5), 144'(3), 1'b0, 1'b0);
    checkOutput("post_add_cycle", 160'(bcyc), 160'(1));
    checkOutput("post_add_r",     160'(bres), 160'(6));

    // Modulus was cleared by reset, so x^144 now reduces to zero.
    bigOp(4'b0011, x143, 144'(2), 1'b0, 1'b0);
    checkOutput("post_mod_r", 160'(bres), 160'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
